// File: rtl/alu_iterative.sv
// Multi-cycle RV32I register-register ALU: single-cycle logic/arithmetic ops,
// iterative shifter moving SHIFT_STEP bits per cycle, result held until taken.
module alu_iterative #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic [XLEN-1:0] register_data_1,
    input  logic [XLEN-1:0] register_data_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] register_data_out
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] STEP_W = SHW'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SHW-1:0]  remaining_q, remaining_d;
    logic            left_q, left_d;
    logic            fill_q, fill_d;

    logic [SHW-1:0]  shamt;
    logic [SHW-1:0]  step;
    logic            is_shift;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] fill_mask;
    logic [XLEN-1:0] shifted;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            result_q    <= '0;
            remaining_q <= '0;
            left_q      <= 1'b0;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            result_q    <= result_d;
            remaining_q <= remaining_d;
            left_q      <= left_d;
            fill_q      <= fill_d;
        end
    end

    // Single-cycle datapath; shift opcodes only reach here with shamt = 0.
    always_comb begin
        shamt    = register_data_2[SHW-1:0];
        is_shift = (funct3[1:0] == 2'b01);
        alu_res  = '0;
        case (funct3)
            3'd0:    alu_res = alt ? (register_data_1 - register_data_2)
                                   : (register_data_1 + register_data_2);
            3'd2:    alu_res = {{(XLEN-1){1'b0}},
                                ($signed(register_data_1) < $signed(register_data_2))};
            3'd3:    alu_res = {{(XLEN-1){1'b0}}, (register_data_1 < register_data_2)};
            3'd4:    alu_res = register_data_1 ^ register_data_2;
            3'd6:    alu_res = register_data_1 | register_data_2;
            3'd7:    alu_res = register_data_1 & register_data_2;
            default: alu_res = register_data_1;
        endcase
    end

    // fill_q already folds the arithmetic flag with the latched operand MSB.
    always_comb begin
        step      = (remaining_q < STEP_W) ? remaining_q : STEP_W;
        fill_mask = ~({XLEN{1'b1}} >> step);
        if (left_q) begin
            shifted = shreg_q << step;
        end else begin
            shifted = (shreg_q >> step) | (fill_q ? fill_mask : '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        result_d    = result_q;
        remaining_d = remaining_q;
        left_d      = left_q;
        fill_d      = fill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_d     = register_data_1;
                        remaining_d = shamt;
                        left_d      = ~funct3[2];
                        fill_d      = funct3[2] & alt & register_data_1[XLEN-1];
                        state_d     = BUSY;
                    end else begin
                        result_d = alu_res;
                        state_d  = HOLD;
                    end
                end
            end
            BUSY: begin
                shreg_d     = shifted;
                remaining_d = remaining_q - step;
                if (remaining_q == step) begin
                    result_d = shifted;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == HOLD);
    assign register_data_out = result_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: SHIFT_STEP=1 and SHIFT_STEP=4 instances driven in
// lockstep and checked against an arithmetic reference model.
module tb_alu_iterative;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        alt = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;

    logic        in_ready1, in_ready4, out_valid1, out_valid4;
    logic [31:0] dout1, dout4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    alu_iterative #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .funct3(funct3), .alt(alt), .register_data_1(opa), .register_data_2(opb),
        .out_valid(out_valid1), .out_ready(out_ready), .register_data_out(dout1)
    );

    alu_iterative #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .funct3(funct3), .alt(alt), .register_data_1(opa), .register_data_2(opb),
        .out_valid(out_valid4), .out_ready(out_ready), .register_data_out(dout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic al,
                                          input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        sh = int'(y % 32);
        case (f)
            3'd0:    return al ? x - y : x + y;
            3'd1:    return x << sh;
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return al ? 32'($signed(x) >>> sh) : x >> sh;
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [2:0] f, input logic [31:0] y,
                                            input int unsigned stp);
        int unsigned sh;
        sh = int'(y % 32);
        if ((f == 3'd1 || f == 3'd5) && sh > 0) return (sh + stp - 1) / stp + 1;
        return 1;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic al, input logic [31:0] x,
                          input logic [31:0] y, input int unsigned hold);
        int unsigned got1, got4;
        logic [31:0] exp;
        exp = model(f, al, x, y);
        @(negedge clk);
        check("in_ready1_idle", {31'b0, in_ready1}, 32'd1);
        check("in_ready4_idle", {31'b0, in_ready4}, 32'd1);
        funct3 = f; alt = al; opa = x; opb = y;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        opa = $urandom; opb = $urandom;
        got1 = 0; got4 = 0;
        for (int n = 1; n <= 40 && (got1 == 0 || got4 == 0); n++) begin
            if (n > 1) @(negedge clk);
            if (n == 1) begin
                check("in_ready1_taken", {31'b0, in_ready1}, 32'd0);
                check("in_ready4_taken", {31'b0, in_ready4}, 32'd0);
            end
            if (got1 == 0 && out_valid1) got1 = n;
            if (got4 == 0 && out_valid4) got4 = n;
        end
        check("latency_step1", 32'(got1), 32'(latency(f, y, 1)));
        check("latency_step4", 32'(got4), 32'(latency(f, y, 4)));
        check("result_step1", dout1, exp);
        check("result_step4", dout4, exp);
        for (int unsigned i = 0; i < hold; i++) begin
            funct3 = 3'($urandom); opa = $urandom; opb = $urandom; in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid1", {31'b0, out_valid1}, 32'd1);
            check("hold_valid4", {31'b0, out_valid4}, 32'd1);
            check("hold_ready1", {31'b0, in_ready1}, 32'd0);
            check("hold_data1", dout1, exp);
            check("hold_data4", dout4, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid1", {31'b0, out_valid1}, 32'd0);
        check("drain_valid4", {31'b0, out_valid4}, 32'd0);
        check("drain_ready1", {31'b0, in_ready1}, 32'd1);
        check("drain_ready4", {31'b0, in_ready4}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid1", {31'b0, out_valid1}, 32'd0);
        check("rst_data1", dout1, 32'd0);
        check("rst_data4", dout4, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready1", {31'b0, in_ready1}, 32'd1);

        run_op(3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(3'd0, 1'b1, 32'h0000_0000, 32'h0000_0001, 0);
        run_op(3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(3'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(3'd5, 1'b1, 32'h8000_0000, 32'd31, 0);
        run_op(3'd5, 1'b0, 32'h8000_0000, 32'd31, 0);
        run_op(3'd1, 1'b0, 32'h0000_0001, 32'hFFFF_FFE4, 0);
        run_op(3'd1, 1'b0, 32'h0000_0001, 32'd0, 5);
        run_op(3'd5, 1'b0, 32'h8000_0000, 32'd7, 0);
        run_op(3'd1, 1'b0, 32'h8000_0001, 32'd31, 1);

        // Abort a shift on its third BUSY cycle.
        @(negedge clk);
        funct3 = 3'd5; alt = 1'b0; opa = 32'hF000_0000; opb = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_valid1", {31'b0, out_valid1}, 32'd0);
        check("abort_valid4", {31'b0, out_valid4}, 32'd0);
        check("abort_data1", dout1, 32'd0);
        check("abort_data4", dout4, 32'd0);
        check("abort_ready1", {31'b0, in_ready1}, 32'd1);
        check("abort_ready4", {31'b0, in_ready4}, 32'd1);
        run_op(3'd4, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Parametrised successor to the single-cycle RV32I register-register ALU. It accepts one operation at a time through a valid/ready handshake and supports the full funct3 set plus the funct7[5] alternate bit (SUB, SRA, signed SLT). Shifts run on an iterative multi-cycle shifter, sized by a parameter, to save area. The result is registered and held until the consumer takes it. The block sits between register-file read and writeback in the execute stage.

## Interface
- XLEN, 32, operand/result width; power of two, at least 8
- SHIFT_STEP, 1, bit positions shifted per cycle in the iterative shifter; power of two, at most XLEN/2
- clock  input  1  rising-edge clock, single clock domain
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation
- funct3  input  3  0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND
- alt  input  1  funct7[5]; selects SUB when funct3=0 and SRA when funct3=5; ignored otherwise
- register_data_1  input  XLEN  operand A
- register_data_2  input  XLEN  operand B; shamt = low log2(XLEN) bits
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- register_data_out  output  XLEN  registered result

## Operation
- Reset (reset_n low at a rising edge): state becomes IDLE; out_valid=0; register_data_out=0; in_ready=1 once out of reset; internal counter and shift register are cleared.
- The block has three states: IDLE, BUSY and HOLD.
- in_ready is high only in IDLE. An operation is accepted when in_valid and in_ready are both high at a rising edge. All inputs are sampled only at that edge.
- IDLE, on accept, with a non-shift op, or a shift with shamt=0:
  - compute the result and register it
  - go to HOLD
- IDLE, on accept, with a shift (funct3 1 or 5) and shamt>0:
  - load operand A into the shift register
  - remaining = shamt; latch the direction and the arithmetic flag
  - go to BUSY
- BUSY: each cycle, shift by min(SHIFT_STEP, remaining) and subtract that amount from remaining.
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the latched operand A MSB.
  - When remaining reaches 0 at that edge, the shift register value becomes register_data_out and the state goes to HOLD.
- HOLD: out_valid=1 and register_data_out is stable. When out_ready is high, go to IDLE and clear out_valid at that edge.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; there is no carry or overflow output.
  - SLT compares as two's-complement signed; SLTU compares unsigned. Both return the value 1 or 0, zero-extended to XLEN.
  - Bits of register_data_2 above shamt are ignored for shifts.
- in_valid asserted outside IDLE has no effect, and the offered operation is not consumed.
- Reset asserted in BUSY or HOLD aborts the operation; no result is produced.

## Timing
- Acceptance in cycle c, non-shift or shamt=0: out_valid high from cycle c+1.
- Acceptance in cycle c, shift with shamt=s>0: BUSY during cycles c+1..c+k, where k=ceil(s/SHIFT_STEP); out_valid high from cycle c+k+1.
- Worst case (XLEN=32, SHIFT_STEP=1, s=31): 32 cycles from acceptance to out_valid.
- In HOLD, out_valid is held for as many cycles as out_ready stays low. register_data_out does not change during that time.
- After the handshake edge, the next acceptance is possible one cycle later, in IDLE. Maximum throughput is one operation per 2 cycles.
- in_ready, out_valid and register_data_out are driven from registers only; none has a combinational path from in_valid or out_ready.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001 with out_ready=1 -> out_valid one cycle after accept; result 0x80000000; in_ready returns high the next cycle.
- SUB (alt=1) 0x00000000 - 0x00000001 -> 0xFFFFFFFF. SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLTU on the same operands -> 0.
- SRA (alt=1) 0x80000000 by shamt 31, SHIFT_STEP=1 -> 31 BUSY cycles, out_valid on the 32nd cycle after accept, result 0xFFFFFFFF. SRL on the same operands -> 0x00000001. SLL 0x00000001 by operand B 0xFFFFFFE4 (shamt 4) -> 0x00000010 after 4 BUSY cycles.
- Backpressure: SLL 0x1 by 0 accepted, out_ready held low for 5 cycles -> out_valid stays high with result 0x00000001 throughout; in_ready stays low; an in_valid offered meanwhile is not accepted until after the handshake.
- Reset mid-shift: SRL 0xF0000000 by 20, reset_n pulled low for 1 cycle on the 3rd BUSY cycle -> out_valid 0, register_data_out 0, in_ready high after reset; a following XOR 0xFF00FF00 ^ 0x0F0F0F0F -> 0xF00FF00F.
- SHIFT_STEP=4, XLEN=32: SRL 0x80000000 by 7 -> k=2 BUSY cycles (4 then 3); result 0x01000000 on cycle c+3.
